// File: rtl/gmii_pkg.sv
// Shared constants and types for the GMII receive timestamping parser.
// Imported by the CRC helper and the top-level parser.
package gmii_pkg;

    localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
    localparam logic [7:0]  GMII_SFD        = 8'hD5;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

    localparam logic [11:0] LEN_SAT  = 12'hFFF;
    localparam logic [2:0]  PCNT_SAT = 3'd7;

    localparam int ERR_RUNT     = 0;
    localparam int ERR_OVERSIZE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic [31:0] ts;
        logic [11:0] len;
        logic        crc_ok;
        logic [1:0]  err;
    } rx_desc_t;

endpackage

// File: rtl/gmii_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC32, LSB of the byte first.
// Purely combinational; the running register is held by the caller.
module gmii_crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_ts_parser.sv
// GMII receive front-end: strips preamble/SFD, timestamps at the SFD,
// forwards DA..FCS with sop/eop, checks CRC32 and emits a descriptor.
module gmii_rx_ts_parser
    import gmii_pkg::*;
#(
    parameter int          MAX_LEN   = 1522,
    parameter int          MIN_LEN   = 64,
    parameter logic [31:0] TS_OFFSET = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] local_clock,
    input  logic [7:0]  RXD,
    input  logic        RXDV,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_desc_valid,
    output logic [31:0] o_desc_ts,
    output logic [11:0] o_desc_len,
    output logic        o_desc_crc_ok,
    output logic [1:0]  o_desc_err,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);

    // Input capture stage; local_clock is captured alongside the byte
    // so the timestamp refers to the edge that sampled the SFD.
    logic [7:0]  rxd_q;
    logic        rxdv_q;
    logic [31:0] lclk_q;

    rx_state_e   state_q, state_d;
    logic [2:0]  pcnt_q, pcnt_d;
    logic [31:0] ts_q, ts_d;
    logic [11:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        first_q, first_d;

    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        desc_valid_q, desc_valid_d;
    rx_desc_t    desc_q, desc_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [31:0] crc_next;
    logic        frame_crc_ok;
    logic [1:0]  frame_err;

    gmii_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (rxd_q),
        .crc_out (crc_next)
    );

    always_comb begin
        frame_crc_ok            = (crc_q == CRC32_RESIDUE) && (len_q >= 12'd4);
        frame_err               = '0;
        frame_err[ERR_RUNT]     = len_q < MIN_L;
        frame_err[ERR_OVERSIZE] = len_q > MAX_L;
    end

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        ts_d         = ts_q;
        len_d        = len_q;
        crc_d        = crc_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        first_d      = first_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        desc_valid_d = 1'b0;
        desc_d       = desc_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rxdv_q) begin
                    if (rxd_q == GMII_PREAMBLE) begin
                        state_d = ST_PREAMBLE;
                        pcnt_d  = 3'd1;
                    end else begin
                        state_d   = ST_DROP;
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!rxdv_q) begin
                    state_d   = ST_IDLE;
                    err_cnt_d = err_cnt_q + 16'd1;
                end else if (rxd_q == GMII_PREAMBLE) begin
                    if (pcnt_q != PCNT_SAT) begin
                        pcnt_d = pcnt_q + 3'd1;
                    end
                end else if (rxd_q == GMII_SFD && pcnt_q != 3'd0) begin
                    state_d    = ST_DATA;
                    ts_d       = lclk_q + TS_OFFSET;
                    len_d      = '0;
                    crc_d      = CRC32_INIT;
                    hold_vld_d = 1'b0;
                    first_d    = 1'b1;
                end else begin
                    state_d   = ST_DROP;
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end

            ST_DATA: begin
                // The held byte leaves now; whether it is the last one
                // is decided by the RXDV of the byte behind it.
                if (hold_vld_q) begin
                    data_d       = hold_q;
                    data_valid_d = 1'b1;
                    sop_d        = first_q;
                    first_d      = 1'b0;
                end
                if (rxdv_q) begin
                    hold_d     = rxd_q;
                    hold_vld_d = 1'b1;
                    crc_d      = crc_next;
                    if (len_q != LEN_SAT) begin
                        len_d = len_q + 12'd1;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q) begin
                        eop_d         = 1'b1;
                        desc_valid_d  = 1'b1;
                        desc_d.ts     = ts_q;
                        desc_d.len    = len_q;
                        desc_d.crc_ok = frame_crc_ok;
                        desc_d.err    = frame_err;
                        frame_cnt_d   = frame_cnt_q + 16'd1;
                        if (!frame_crc_ok || frame_err != 2'b00) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
            end

            ST_DROP: begin
                if (!rxdv_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q        <= '0;
            rxdv_q       <= 1'b0;
            lclk_q       <= '0;
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            ts_q         <= '0;
            len_q        <= '0;
            crc_q        <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            first_q      <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            desc_valid_q <= 1'b0;
            desc_q       <= '0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            rxd_q        <= RXD;
            rxdv_q       <= RXDV;
            lclk_q       <= local_clock;
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            ts_q         <= ts_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            first_q      <= first_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            desc_valid_q <= desc_valid_d;
            desc_q       <= desc_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = data_valid_q;
    assign o_sop         = sop_q;
    assign o_eop         = eop_q;
    assign o_desc_valid  = desc_valid_q;
    assign o_desc_ts     = desc_q.ts;
    assign o_desc_len    = desc_q.len;
    assign o_desc_crc_ok = desc_q.crc_ok;
    assign o_desc_err    = desc_q.err;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_err_cnt     = err_cnt_q;

endmodule
